// File: rtl/data_mem_if.sv
// Request/response handshake between a load/store initiator and the data memory.
interface data_mem_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ready;
   logic        busy;
   logic        err;

   modport master (output MemRead, MemWrite, addr, wd,
                   input  rd, ready, busy, err);
   modport slave  (input  MemRead, MemWrite, addr, wd,
                   output rd, ready, busy, err);
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and fault reporting
// for misaligned, out-of-range and conflicting read/write requests.
module data_mem_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_WORDS = 256
) (
   input  logic      clk,
   input  logic      rst,
   data_mem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [31:0]   addr_q;
   logic [31:0]   wd_q;
   logic          rd_op_q;
   logic          wr_op_q;
   logic [31:0]   rd_q;
   logic [31:0]   rd_now;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          req;
   logic          accept;
   logic [AW-1:0] idx;
   logic          misaligned;
   logic          out_of_range;
   logic          fault;
   logic          do_read;
   logic          do_write;
   logic          zero_read;

   assign req    = bus.MemRead | bus.MemWrite;
   assign accept = (state == IDLE) & req;

   // Index is a plain slice of the latched address; upper bits only feed the range check.
   assign idx          = addr_q[AW+1:2];
   assign misaligned   = (addr_q[1:0] != 2'b00);
   assign out_of_range = |addr_q[31:AW+2];
   assign fault        = misaligned | out_of_range | (rd_op_q & wr_op_q);

   assign do_read   = (state == DONE) & rd_op_q & ~fault;
   assign do_write  = (state == DONE) & wr_op_q & ~fault;
   assign zero_read = (state == DONE) & rd_op_q & ~wr_op_q & ~misaligned & out_of_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (WAIT_CYCLES > 0) ? WAIT : DONE;
         WAIT:    if (cnt <= 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_now = rd_q;
      if (do_read)        rd_now = mem[idx];
      else if (zero_read) rd_now = '0;
   end

   always_comb begin
      bus.ready = (state == DONE);
      bus.busy  = (state != IDLE);
      bus.err   = (state == DONE) & fault;
      bus.rd    = rd_now;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (accept)        cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT) cnt <= cnt - 4'd1;
   end

   // rd keeps the last completed read so it stays stable across writes and idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                rd_q <= '0;
      else if (state == DONE) rd_q <= rd_now;
   end

   // Request fields are captured once so input changes during wait states are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus.addr;
         wd_q    <= bus.wd;
         rd_op_q <= bus.MemRead;
         wr_op_q <= bus.MemWrite;
      end
      if (do_write) mem[idx] <= wd_q;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 2 wait states) checked against a behavioural model.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem_m [2][256];
   logic [31:0] rd_m  [2];

   data_mem_if b0 ();
   data_mem_if b2 ();

   data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   function automatic int wc(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic logic get_ready(input int d);
      return (d == 0) ? b0.ready : b2.ready;
   endfunction
   function automatic logic get_busy(input int d);
      return (d == 0) ? b0.busy : b2.busy;
   endfunction
   function automatic logic get_err(input int d);
      return (d == 0) ? b0.err : b2.err;
   endfunction
   function automatic logic [31:0] get_rd(input int d);
      return (d == 0) ? b0.rd : b2.rd;
   endfunction

   task automatic drive(input int d, input bit r, input bit w, input logic [31:0] ad, input logic [31:0] wdat);
      if (d == 0) begin
         b0.MemRead = r; b0.MemWrite = w; b0.addr = ad; b0.wd = wdat;
      end else begin
         b2.MemRead = r; b2.MemWrite = w; b2.addr = ad; b2.wd = wdat;
      end
   endtask

   // Reference behaviour: what one completed request does to memory and rd.
   task automatic model(input int d, input bit r, input bit w, input logic [31:0] ad,
                        input logic [31:0] wdat, output bit e_err, output logic [31:0] e_rd);
      bit conflict  = r && w;
      bit unaligned = (ad % 4) != 0;
      bit beyond    = ad >= 32'd1024;
      e_err = conflict || unaligned || beyond;
      if (!conflict && !unaligned) begin
         if (beyond) begin
            if (r) rd_m[d] = 32'h0;
         end else if (r) begin
            rd_m[d] = mem_m[d][int'(ad >> 2)];
         end else if (w) begin
            mem_m[d][int'(ad >> 2)] = wdat;
         end
      end
      e_rd = rd_m[d];
   endtask

   // Presents a request and holds it until ready; lat counts rising edges until the ready cycle.
   task automatic xact(input int d, input bit r, input bit w, input logic [31:0] ad, input logic [31:0] wdat,
                       output int lat, output logic e, output logic [31:0] rdata, output logic bsy);
      drive(d, r, w, ad, wdat);
      lat = -1; e = 1'bx; rdata = 'x; bsy = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (get_ready(d) === 1'b1) begin
            lat = n; e = get_err(d); rdata = get_rd(d); bsy = get_busy(d);
            break;
         end
      end
      drive(d, 1'b0, 1'b0, ad, wdat);
   endtask

   task automatic test_reset;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++; if (get_ready(d) !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, get_ready(d)); end
         checks++; if (get_busy(d)  !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, get_busy(d)); end
         checks++; if (get_err(d)   !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, get_err(d)); end
         checks++; if (get_rd(d) !== 32'h0) begin errors++; $display("FAIL reset_rd[%0d]: got %h expected 0", d, get_rd(d)); end
      end
      rst = 1'b0;
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_write_read_wait2;
      int lat; logic e, bsy; logic [31:0] got, exp_rd; bit exp_err;
      xact(1, 0, 1, 32'h10, 32'hDEADBEEF, lat, e, got, bsy);
      model(1, 0, 1, 32'h10, 32'hDEADBEEF, exp_err, exp_rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL w2_write_lat: got %0d expected 3", lat); end
      checks++; if (e !== exp_err) begin errors++; $display("FAIL w2_write_err: got %b expected %b", e, exp_err); end
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL w2_busy_done: got %b expected 1", bsy); end
      @(negedge clk);
      checks++; if (get_busy(1) !== 1'b0) begin errors++; $display("FAIL w2_busy_idle: got %b expected 0", get_busy(1)); end
      xact(1, 1, 0, 32'h10, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h10, 32'h0, exp_err, exp_rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL w2_read_lat: got %0d expected 3", lat); end
      checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL w2_read_rd: got %h expected deadbeef", got); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL w2_read_err: got %b expected 0", e); end
      @(negedge clk);
      checks++; if (get_rd(1) !== exp_rd) begin errors++; $display("FAIL w2_rd_hold: got %h expected %h", get_rd(1), exp_rd); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] adrs [4];
      bit          isw  [4];
      logic [31:0] dat  [4];
      int lat; logic e, bsy; logic [31:0] got, exp_rd; bit exp_err;
      adrs = '{32'h0, 32'h4, 32'h0, 32'h4};
      isw  = '{1'b1, 1'b1, 1'b0, 1'b0};
      dat  = '{$urandom, $urandom, 32'h0, 32'h0};
      for (int i = 0; i < 4; i++) begin
         xact(0, !isw[i], isw[i], adrs[i], dat[i], lat, e, got, bsy);
         model(0, !isw[i], isw[i], adrs[i], dat[i], exp_err, exp_rd);
         checks++; if (lat !== ((i == 0) ? 1 : 2)) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d expected %0d", i, lat, (i == 0) ? 1 : 2); end
         checks++; if (got !== exp_rd) begin errors++; $display("FAIL b2b_rd[%0d]: got %h expected %h", i, got, exp_rd); end
         checks++; if (e !== exp_err) begin errors++; $display("FAIL b2b_err[%0d]: got %b expected %b", i, e, exp_err); end
      end
      @(negedge clk);
   endtask

   task automatic test_faults;
      int lat; logic e, bsy; logic [31:0] got, exp_rd; bit exp_err;
      xact(1, 1, 0, 32'h13, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h13, 32'h0, exp_err, exp_rd);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", e); end
      checks++; if (got !== exp_rd) begin errors++; $display("FAIL misalign_rd: got %h expected %h", got, exp_rd); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL misalign_lat: got %0d expected 3", lat); end
      @(negedge clk);
      xact(1, 1, 0, 32'h400, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h400, 32'h0, exp_err, exp_rd);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", e); end
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL range_rd: got %h expected 0", got); end
      @(negedge clk);
      checks++; if (get_err(1) !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", get_err(1)); end
   endtask

   task automatic test_both_ops;
      int lat; logic e, bsy; logic [31:0] got, exp_rd; bit exp_err;
      xact(1, 0, 1, 32'h8, 32'h12345678, lat, e, got, bsy);
      model(1, 0, 1, 32'h8, 32'h12345678, exp_err, exp_rd);
      @(negedge clk);
      xact(1, 1, 1, 32'h8, 32'hCAFEF00D, lat, e, got, bsy);
      model(1, 1, 1, 32'h8, 32'hCAFEF00D, exp_err, exp_rd);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL both_err: got %b expected 1", e); end
      checks++; if (got !== exp_rd) begin errors++; $display("FAIL both_rd: got %h expected %h", got, exp_rd); end
      @(negedge clk);
      xact(1, 1, 0, 32'h8, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h8, 32'h0, exp_err, exp_rd);
      checks++; if (got !== 32'h12345678) begin errors++; $display("FAIL both_after_rd: got %h expected 12345678", got); end
      @(negedge clk);
   endtask

   task automatic test_reset_during_wait;
      int lat, pulses; logic e, bsy; logic [31:0] got, exp_rd, prior; bit exp_err;
      prior = $urandom;
      xact(1, 0, 1, 32'h20, prior, lat, e, got, bsy);
      model(1, 0, 1, 32'h20, prior, exp_err, exp_rd);
      @(negedge clk);
      drive(1, 0, 1, 32'h20, 32'hAAAA5555);
      @(posedge clk);
      @(negedge clk);
      checks++; if (get_busy(1) !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b expected 1", get_busy(1)); end
      rst = 1'b1;
      #1;
      checks++; if (get_busy(1)  !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", get_busy(1)); end
      checks++; if (get_ready(1) !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", get_ready(1)); end
      checks++; if (get_rd(1) !== 32'h0) begin errors++; $display("FAIL abort_rd: got %h expected 0", get_rd(1)); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (get_ready(1) !== 1'b0) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready_pulses: got %0d expected 0", pulses); end
      drive(1, 0, 0, 32'h0, 32'h0);
      rst = 1'b0;
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;
      @(negedge clk);
      xact(1, 1, 0, 32'h20, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h20, 32'h0, exp_err, exp_rd);
      checks++; if (got !== prior) begin errors++; $display("FAIL abort_mem_kept: got %h expected %h", got, prior); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL abort_next_lat: got %0d expected 3", lat); end
      @(negedge clk);
   endtask

   task automatic test_input_change_during_wait;
      int lat; logic e, bsy; logic [31:0] got, exp_rd, q, v; bit exp_err;
      q = $urandom;
      v = $urandom;
      xact(1, 0, 1, 32'h40, q, lat, e, got, bsy);
      model(1, 0, 1, 32'h40, q, exp_err, exp_rd);
      @(negedge clk);
      drive(1, 0, 1, 32'h30, v);
      @(posedge clk);
      @(negedge clk);
      drive(1, 0, 1, 32'h40, ~v);
      lat = -1;
      for (int n = 2; n <= 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (get_ready(1) === 1'b1) begin lat = n; e = get_err(1); break; end
      end
      drive(1, 0, 0, 32'h0, 32'h0);
      model(1, 0, 1, 32'h30, v, exp_err, exp_rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL latch_lat: got %0d expected 3", lat); end
      @(negedge clk);
      xact(1, 1, 0, 32'h30, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h30, 32'h0, exp_err, exp_rd);
      checks++; if (got !== v) begin errors++; $display("FAIL latch_rd30: got %h expected %h", got, v); end
      @(negedge clk);
      xact(1, 1, 0, 32'h40, 32'h0, lat, e, got, bsy);
      model(1, 1, 0, 32'h40, 32'h0, exp_err, exp_rd);
      checks++; if (got !== q) begin errors++; $display("FAIL latch_rd40: got %h expected %h", got, q); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int lat, exp_lat, d, prev_d, k; logic e, bsy; logic [31:0] got, exp_rd, ad, wdat; bit exp_err, r, w, gap;
      for (int dd = 0; dd < 2; dd++) begin
         for (int i = 0; i < 16; i++) begin
            wdat = $urandom;
            xact(dd, 0, 1, 32'(i * 4), wdat, lat, e, got, bsy);
            model(dd, 0, 1, 32'(i * 4), wdat, exp_err, exp_rd);
            checks++; if (lat !== wc(dd) + 1) begin errors++; $display("FAIL fill_lat[%0d]: got %0d expected %0d", i, lat, wc(dd) + 1); end
            @(negedge clk);
         end
      end
      prev_d = -1;
      for (int t = 0; t < 60; t++) begin
         d    = $urandom_range(0, 1);
         gap  = 1'($urandom_range(0, 1));
         k    = $urandom_range(0, 9);
         wdat = $urandom;
         ad   = 32'($urandom_range(0, 15) * 4);
         r = (k <= 3) || (k == 7);
         w = (k >= 4 && k <= 7);
         if (k == 8) begin ad = ad + 32'($urandom_range(1, 3)); r = 1'($urandom_range(0, 1)); w = !r; end
         if (k == 9) begin ad = ($urandom | 32'h400) & 32'hFFFF_FFFC; r = 1'($urandom_range(0, 1)); w = !r; end
         if (gap) begin
            @(negedge clk);
            checks++; if (get_busy(d) !== 1'b0) begin errors++; $display("FAIL rnd_busy_idle[%0d]: got %b expected 0", t, get_busy(d)); end
         end
         exp_lat = (gap || d != prev_d) ? wc(d) + 1 : wc(d) + 2;
         xact(d, r, w, ad, wdat, lat, e, got, bsy);
         model(d, r, w, ad, wdat, exp_err, exp_rd);
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", t, lat, exp_lat); end
         checks++; if (e !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b addr %h", t, e, exp_err, ad); end
         checks++; if (got !== exp_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %h expected %h addr %h", t, got, exp_rd, ad); end
         prev_d = d;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write_read_wait2();
      test_back_to_back();
      test_faults();
      test_both_ops();
      test_reset_during_wait();
      test_input_change_during_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
